// File: rtl/caster_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// caster_pkg : constants and FSM encoding for the EPD state-buffer RMW engine.
// Rev 1.0
// ----------------------------------------------------------------------------
package caster_pkg;

   localparam int AW = 14;

   // stored pixel state bits
   localparam int ST_BUSY  = 1;
   localparam int ST_COLOR = 0;

   localparam logic [1:0] DRV_NONE  = 2'b00;
   localparam logic [1:0] DRV_BLACK = 2'b01;
   localparam logic [1:0] DRV_WHITE = 2'b10;

   localparam int FSM_W = 3;
   typedef logic [FSM_W-1:0] fsm_t;

   localparam fsm_t S_IDLE  = 3'd0;
   localparam fsm_t S_PRIME = 3'd1;
   localparam fsm_t S_RUN   = 3'd2;
   localparam fsm_t S_DRAIN = 3'd3;
   localparam fsm_t S_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/epd_pixel_update.sv
`default_nettype none
// ----------------------------------------------------------------------------
// epd_pixel_update : per-pixel drive code and next stored state.
// Rev 1.0
// ----------------------------------------------------------------------------
module epd_pixel_update
   import caster_pkg::*;
(
   input  logic [1:0] state,
   input  logic       target,
   input  logic       frame_last,
   output logic [1:0] drive,
   output logic [1:0] new_state
);

   always_comb begin
      drive     = DRV_NONE;
      new_state = state;
      if (state[ST_BUSY]) begin
         // pixel already moving: keep driving until the last frame retires it
         drive = state[ST_COLOR] ? DRV_BLACK : DRV_WHITE;
         if (frame_last) begin
            new_state = {1'b0, state[ST_COLOR]};
         end
      end else if (target != state[ST_COLOR]) begin
         drive     = target ? DRV_BLACK : DRV_WHITE;
         new_state = {1'b1, target};
      end
   end

endmodule
`default_nettype wire

// File: rtl/epd_state_rmw.sv
`default_nettype none
// ----------------------------------------------------------------------------
// epd_state_rmw : line-based read-modify-write of the 2-bit pixel state RAM.
// Optional EPD_STATE_RMW_BUSYCNT_EN adds busy_count output.  Rev 1.0
// ----------------------------------------------------------------------------
module epd_state_rmw #(
   parameter int AW = caster_pkg::AW,
   parameter int LW = 14
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [LW-1:0] length,
   input  logic          frame_last,
   output logic          busy,
   output logic          done,
   input  logic          pix_valid,
   output logic          pix_ready,
   input  logic          pix_target,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    out_drive,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [1:0]    mem_rd_data,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_wr_addr,
   output logic [1:0]    mem_wr_data
`ifdef EPD_STATE_RMW_BUSYCNT_EN
   ,
   output logic [LW:0]   busy_count
`endif
);
   import caster_pkg::*;

   fsm_t          state_q, state_d;
   logic [AW-1:0] cur_q, cur_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          fl_q, fl_d;
   logic          out_valid_q, out_valid_d;
   logic [1:0]    out_drive_q, out_drive_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [1:0]    wr_data_q, wr_data_d;
   logic          fire;
   logic          last;
   logic [1:0]    upd_drive;
   logic [1:0]    upd_state;

   epd_pixel_update u_update (
      .state      (mem_rd_data),
      .target     (pix_target),
      .frame_last (fl_q),
      .drive      (upd_drive),
      .new_state  (upd_state)
   );

   assign fire = pix_valid && pix_ready;
   assign last = (cnt_q == LW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         cnt_q       <= '0;
         fl_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_drive_q <= DRV_NONE;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         cnt_q       <= cnt_d;
         fl_q        <= fl_d;
         out_valid_q <= out_valid_d;
         out_drive_q <= out_drive_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (length == '0) ? S_DONE : S_PRIME;
         S_PRIME: state_d = S_RUN;
         S_RUN:   if (fire && last) state_d = S_DRAIN;
         S_DRAIN: if (!out_valid_q || out_ready) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_PRIME, S_RUN, S_DRAIN: busy = 1'b1;
         S_DONE:                  done = 1'b1;
         default: ;
      endcase
      pix_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
   end

   always_comb begin
      cur_d       = cur_q;
      cnt_d       = cnt_q;
      fl_d        = fl_q;
      out_valid_d = out_valid_q && !out_ready;
      out_drive_d = out_drive_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      mem_rd_addr = cur_q;
      if ((state_q == S_IDLE) && start && (length != '0)) begin
         cur_d       = base_addr;
         cnt_d       = length;
         fl_d        = frame_last;
         mem_rd_addr = base_addr;
      end
      if (fire) begin
         out_valid_d = 1'b1;
         out_drive_d = upd_drive;
         wr_en_d     = 1'b1;
         wr_addr_d   = cur_q;
         wr_data_d   = upd_state;
         cnt_d       = cnt_q - LW'(1);
         // stalls hold the address so the RAM simply re-reads the same pixel;
         // the last pixel does not prefetch beyond the line
         if (!last) begin
            cur_d       = cur_q + AW'(1);
            mem_rd_addr = cur_q + AW'(1);
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_drive   = out_drive_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;

`ifdef EPD_STATE_RMW_BUSYCNT_EN
   logic [LW:0] bcnt_q, bcnt_d;

   always_comb begin
      bcnt_d = bcnt_q;
      if ((state_q == S_IDLE) && start) begin
         bcnt_d = '0;
      end else if (fire && upd_state[ST_BUSY]) begin
         bcnt_d = bcnt_q + (LW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bcnt_q <= '0;
      else        bcnt_q <= bcnt_d;
   end

   assign busy_count = bcnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_epd_state_rmw.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_epd_state_rmw : directed + randomized bench with a line-level RAM model.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_epd_state_rmw;
   localparam int AW    = 14;
   localparam int LW    = 14;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] length = '0;
   logic          frame_last = 1'b0;
   logic          busy, done, pix_ready, out_valid, mem_wr_en;
   logic          pix_valid = 1'b0;
   logic          pix_target = 1'b0;
   logic          out_ready = 1'b0;
   logic [1:0]    out_drive, mem_wr_data;
   logic [1:0]    mem_rd_data = 2'b00;
   logic [AW-1:0] mem_rd_addr, mem_wr_addr;
`ifdef EPD_STATE_RMW_BUSYCNT_EN
   logic [LW:0]   busy_count;
`endif

   always #5 clk = ~clk;

   epd_state_rmw #(.AW(AW), .LW(LW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .length(length), .frame_last(frame_last), .busy(busy), .done(done),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_target(pix_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_drive(out_drive),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
`ifdef EPD_STATE_RMW_BUSYCNT_EN
      , .busy_count(busy_count)
`endif
   );

   // dual-port state RAM; the bench can preload through its own write port
   logic [1:0]    ram [DEPTH];
   logic          tb_we = 1'b0;
   logic [AW-1:0] tb_wa = '0;
   logic [1:0]    tb_wd = '0;
   always @(posedge clk) begin
      mem_rd_data <= ram[mem_rd_addr];
      if (tb_we)          ram[tb_wa] <= tb_wd;
      else if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
   end

   logic [1:0] model [DEPTH];
   bit         known [DEPTH];
   logic       tgt   [64];
   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic preset(input int a, input logic [1:0] v);
      @(posedge clk); #1;
      tb_we = 1'b1; tb_wa = AW'(a); tb_wd = v;
      @(posedge clk); #1;
      tb_we = 1'b0;
      model[a] = v;
      known[a] = 1'b1;
   endtask

   // Runs one line: predicts drives/writes from the stored-state rules, then
   // compares against what the DUT actually emitted and left in RAM.
   task automatic run_line(input int base, input int len, input logic fl,
                           input int gap_pct, input int stall_pct, input bit junk_start);
      int exp_drv[$], exp_wr[$], got_drv[$], got_wr[$];
      int exp_bc, n_done, cyc, last_hs, done_cyc, bad_rd, busy_seen, idx, budget;
      exp_bc = 0; n_done = 0; cyc = 0; last_hs = -10; done_cyc = -1;
      bad_rd = 0; busy_seen = 0; idx = 0; budget = 20 * len + 50;
      for (int i = 0; i < len; i++) begin
         int a = (base + i) % DEPTH;
         if (!known[a]) preset(a, 2'($urandom_range(0, 3)));
      end
      for (int i = 0; i < len; i++) begin
         int a = (base + i) % DEPTH;
         logic [1:0] s, ns;
         int drv;
         s = model[a];
         if (s[1]) begin
            drv = s[0] ? 1 : 2;
            ns  = fl ? {1'b0, s[0]} : s;
         end else if (tgt[i] != s[0]) begin
            drv = tgt[i] ? 1 : 2;
            ns  = {1'b1, tgt[i]};
         end else begin
            drv = 0;
            ns  = s;
         end
         exp_drv.push_back(drv);
         exp_wr.push_back(a * 4 + int'(ns));
         exp_bc += int'(ns[1]);
         model[a] = ns;
      end

      @(posedge clk); #1;
      start = 1'b1; base_addr = AW'(base); length = LW'(len); frame_last = fl;
      pix_valid = 1'b0; out_ready = 1'b1;
      while (n_done == 0 && cyc < budget) begin
         @(negedge clk);
         if (pix_valid && pix_ready) idx++;
         if (out_valid && out_ready) begin got_drv.push_back(int'(out_drive)); last_hs = cyc; end
         if (mem_wr_en) got_wr.push_back(int'(mem_wr_addr) * 4 + int'(mem_wr_data));
         if (busy) begin
            busy_seen++;
            if (((int'(mem_rd_addr) - base + DEPTH) % DEPTH) >= len) bad_rd++;
         end
         if (done) begin n_done++; done_cyc = cyc; end
         @(posedge clk); #1;
         start = junk_start && (cyc == 4);
         if (start) begin base_addr = ~AW'(base); length = LW'(3); end
         pix_valid  = (idx < len) && ($urandom_range(0, 99) >= gap_pct);
         pix_target = (idx < len) ? tgt[idx] : 1'b0;
         out_ready  = ($urandom_range(0, 99) >= stall_pct);
         cyc++;
      end
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done) n_done++;
         if (mem_wr_en) got_wr.push_back(-1);
         @(posedge clk); #1;
      end
      pix_valid = 1'b0; out_ready = 1'b1;

      check("done_pulses", n_done, 1);
      check("drive_count", got_drv.size(), len);
      check("write_count", got_wr.size(), len);
      for (int i = 0; i < len; i++) begin
         check("drive", (i < got_drv.size()) ? got_drv[i] : -1, exp_drv[i]);
         check("write", (i < got_wr.size()) ? got_wr[i] : -1, exp_wr[i]);
         check("ram", ram[(base + i) % DEPTH], model[(base + i) % DEPTH]);
      end
      if (len > 0) begin
         check("done_latency", done_cyc, last_hs + 1);
         check("read_outside_line", bad_rd, 0);
      end else begin
         check("busy_len0", busy_seen, 0);
      end
      check("busy_after", busy, 0);
`ifdef EPD_STATE_RMW_BUSYCNT_EN
      check("busy_count", busy_count, exp_bc);
`endif
   endtask

   initial begin
      int cyc, wr_seen, idx;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pix_ready", pix_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_out_drive", out_drive, 0);
      check("rst_rd_addr", mem_rd_addr, 0);
      check("rst_wr_addr", mem_wr_addr, 0);
      check("rst_wr_data", mem_wr_data, 0);
      rst_n = 1'b1;

      // basic line, then the final-frame pass over the same pixels
      for (int a = 0; a < 4; a++) preset(a, 2'b00);
      tgt[0] = 1'b1; tgt[1] = 1'b0; tgt[2] = 1'b1; tgt[3] = 1'b1;
      run_line(0, 4, 1'b0, 0, 0, 1'b0);
      check("t1_ram0", ram[0], 3); check("t1_ram1", ram[1], 0);
      check("t1_ram2", ram[2], 3); check("t1_ram3", ram[3], 3);
      run_line(0, 4, 1'b1, 0, 0, 1'b0);
      check("t2_ram0", ram[0], 1); check("t2_ram1", ram[1], 0);
      check("t2_ram2", ram[2], 1); check("t2_ram3", ram[3], 1);

      // back-pressure and input gaps
      for (int a = 0; a < 4; a++) preset(a, 2'b00);
      run_line(0, 4, 1'b0, 40, 50, 1'b0);
      check("t3_ram0", ram[0], 3); check("t3_ram1", ram[1], 0);
      check("t3_ram2", ram[2], 3); check("t3_ram3", ram[3], 3);

      // address wrap at the top of the RAM
      for (int i = 0; i < 4; i++) tgt[i] = 1'($urandom_range(0, 1));
      run_line(DEPTH - 2, 4, 1'b0, 20, 20, 1'b0);

      // reset in the middle of a line
      for (int a = 0; a < 4; a++) preset(a, 2'b00);
      for (int i = 0; i < 4; i++) tgt[i] = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; base_addr = '0; length = LW'(4); frame_last = 1'b0;
      out_ready = 1'b1; pix_valid = 1'b1; pix_target = 1'b1;
      cyc = 0; wr_seen = 0; idx = 0;
      while (wr_seen < 2 && cyc < 40) begin
         @(negedge clk);
         if (mem_wr_en) wr_seen++;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      check("rst_mid_reached", wr_seen, 2);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_wr_en", mem_wr_en, 0);
      pix_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mid_ram0", ram[0], 3); check("rst_mid_ram1", ram[1], 3);
      check("rst_mid_ram2", ram[2], 0); check("rst_mid_ram3", ram[3], 0);
      model[0] = 2'b11; model[1] = 2'b11;
      rst_n = 1'b1;
      run_line(0, 4, 1'b0, 0, 0, 1'b0);

      // empty line, then a start issued while busy
      run_line(5, 0, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 12; i++) tgt[i] = 1'($urandom_range(0, 1));
      run_line(100, 12, 1'b0, 20, 20, 1'b1);

      // randomized lines
      for (int n = 0; n < 10; n++) begin
         int b, l;
         b = $urandom_range(0, DEPTH - 1);
         l = $urandom_range(1, 40);
         for (int i = 0; i < l; i++) tgt[i] = 1'($urandom_range(0, 1));
         run_line(b, l, 1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom_range(0, 40), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/epd_state_rmw.md
Name: epd_state_rmw

Overview:
- Read-modify-write engine for the 2-bit per-pixel state buffer: the client end of the dual-port state RAM.
- For each line it reads each pixel's stored state from one RAM port and combines it with the incoming target colour.
- It emits a per-pixel drive code downstream and writes the updated state back through the other RAM port.
- Sits between the frame/line sequencer and the waveform/output stage; full rate, one pixel per cycle.

Parameters:
- AW, 14, state RAM address width (16384 pixels)
- LW, 14, line length counter width

Ports:
- clk  in  1  system clock; RAM ports are clocked by the same clk
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle line start; ignored while busy
- base_addr  in  AW  first pixel address of the line
- length  in  LW  pixel count, 0..16383
- frame_last  in  1  current frame is the last waveform frame; sampled at start
- busy  out  1  line in progress
- done  out  1  single-cycle pulse at line completion
- pix_valid  in  1  target pixel available
- pix_ready  out  1  target pixel accepted
- pix_target  in  1  target colour, 1=black, 0=white
- out_valid  out  1  drive code valid
- out_ready  in  1  downstream accepts drive code
- out_drive  out  2  00 none, 01 toward black, 10 toward white
- mem_rd_addr  out  AW  to RAM port A, addra; wea tied 0
- mem_rd_data  in  2  from RAM port A, douta; 1-cycle read latency
- mem_wr_en  out  1  to RAM port B, web
- mem_wr_addr  out  AW  to RAM port B, addrb
- mem_wr_data  out  2  to RAM port B, dinb

Behaviour:
- Stored state encoding: bit1 = in-transition, bit0 = current colour.
- Reset values: busy, done, pix_ready, out_valid, mem_wr_en = 0; out_drive = 00; mem_rd_addr, mem_wr_addr, mem_wr_data = 0; FSM = IDLE.
- FSM states: IDLE, PRIME, RUN, DRAIN, DONE.
- IDLE, start with length=0: go to DONE. No RAM reads or writes.
- IDLE, start with length>0: latch base_addr, length and frame_last; drive mem_rd_addr=base; go to PRIME.
- PRIME lasts one cycle while the RAM returns data; then go to RUN.
- pix_ready = (RUN) and (!out_valid or out_ready).
- fire = pix_valid and pix_ready.
- mem_rd_addr is combinational: cur+1 on fire, else cur. While stalled the address is held, so the RAM re-reads the same location and no skid buffer is needed.
- Update rule, with s = mem_rd_data and t = pix_target:
  - s[1]=0 and t!=s[0]: drive toward t; new state = {1,t}.
  - s[1]=1: drive toward s[0]; new state = frame_last ? {0,s[0]} : s.
  - otherwise: drive 00; state unchanged.
- On fire, these are registered at the same edge: out_drive; out_valid=1; mem_wr_en=1 with the pixel's address and new state.
- mem_wr_en is a one-cycle pulse per pixel. A write always rewrites the stored value, including when it is unchanged.
- out_valid holds until out_ready.
- Addresses are base+index modulo 2^AW, so lines wrap at 16383->0.
- Since length<=16383, the read and write addresses never collide.
- After the fire of the last pixel, go to DRAIN. DRAIN holds until out_valid is clear or out_ready=1; then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- busy is high from the cycle after start through DRAIN.
- Reset mid-line: all outputs return to reset values immediately. RAM keeps whatever was already written; partial-line updates are not undone.

Optional Feature:
- Macro: EPD_STATE_RMW_BUSYCNT_EN.
- Defined: adds output busy_count[LW:0], the number of pixels written with new state bit1=1 during the line. Cleared on an accepted start; stable from the done pulse until the next start.
- Undefined: port and counter absent.

Decomposition:
- Shared package caster_pkg holds:
  - state-bit positions (ST_BUSY=1, ST_COLOR=0)
  - drive code constants DRV_NONE, DRV_BLACK, DRV_WHITE
  - AW
  - FSM state encoding
- One combinational sub-module, epd_pixel_update: inputs state, target, frame_last; outputs drive code and new state. Shared with future waveform variants.

Test Plan:
- RAM[0..3]=00, base=0, length=4, targets 1,0,1,1, frame_last=0, out_ready=1 -> drives 01,00,01,01 on consecutive cycles; RAM[0..3]=11,00,11,11; done 1 cycle after last accepted output.
- Repeat on the same line with frame_last=1, targets unchanged -> drives 01,00,01,01; RAM=01,00,01,01.
- Test 1 with out_ready toggling 1,0,1,0 and pix_valid gaps -> no drop or duplicate; order preserved; exactly 4 mem_wr_en pulses; same final RAM.
- base=16382, length=4 -> reads and writes at 16382, 16383, 0, 1 only.
- Assert rst_n low after 2 pixels are written, then release -> busy, out_valid, mem_wr_en all 0; RAM[0..1] updated, RAM[2..3] untouched; a fresh start completes normally.
- length=0 start -> done pulses exactly once; no mem_wr_en. A start while busy -> ignored; base and length unchanged.
